// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time instruction-memory loader. Receives a byte stream laid out as
//   [N lo][N hi][4*N data bytes, little-endian words][optional checksum byte]
//   and writes each completed 32-bit word into the instruction memory. The
//   core is held stalled until a load finishes successfully.
//
// Build option:
//   LOADER_CHECKSUM_EN - when defined, a running XOR of all data bytes is kept
//                        and compared against one trailing checksum byte.
//
// Ports:
//   i_clk         clock, all state changes on rising edge
//   i_reset       asynchronous active-high reset
//   i_start       one-cycle load request (honoured in IDLE/DONE/ERR only)
//   i_byte_valid  byte stream valid
//   i_byte_data   byte stream data
//   o_byte_ready  loader takes a byte this cycle
//   o_we          one-cycle word write strobe
//   o_waddr       word address of the write (held between strobes)
//   o_wdata       word data of the write (held between strobes)
//   o_busy        load in progress
//   o_done        last load completed successfully
//   o_err         last load aborted on an error
//   o_cpu_stall   freezes core PC/fetch (low only after a good load)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W    = 11,
    parameter int MAX_WORDS = 2048
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [31:0]       o_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_cpu_stall
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       nlen_q;
    // One bit wider than the address so N = MAX_WORDS ends without wrapping.
    logic [ADDR_W:0]   cnt_q;
    logic [1:0]        bidx_q;
    logic [23:0]       asm_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic              accept;
    logic              can_start;
    logic [15:0]       nlen_hdr;
    logic [ADDR_W:0]   cnt_inc;
    logic              last_word;
    logic              word_done;

    assign accept    = i_byte_valid & o_byte_ready;
    assign can_start = i_start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));
    // Full length as it will be once the high header byte lands.
    assign nlen_hdr  = {i_byte_data, nlen_q[7:0]};
    assign cnt_inc   = cnt_q + CNT_ONE;
    assign last_word = (32'(cnt_inc) == 32'(nlen_q));
    assign word_done = accept & (state_q == S_DATA) & (bidx_q == 2'd3);

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) state_d = S_HDR0;
            end
            S_HDR0: begin
                if (accept) state_d = S_HDR1;
            end
            S_HDR1: begin
                if (accept) begin
                    if ((nlen_hdr == 16'd0) || (32'(nlen_hdr) > MAX_W)) state_d = S_ERR;
                    else                                                 state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (word_done && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_d = (i_byte_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_byte_ready = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_cpu_stall  = 1'b1;
        case (state_q)
            S_HDR0, S_HDR1, S_DATA: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
            end
`endif
            S_DONE: begin
                o_done      = 1'b1;
                o_cpu_stall = 1'b0;
            end
            S_ERR: begin
                o_err = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: header capture, word assembly, write port, checksum.
    // The write strobe is registered so the async reset also kills a write
    // that was launched by a 4th byte in the previous cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            nlen_q  <= '0;
            cnt_q   <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            if (can_start) begin
                cnt_q  <= '0;
                bidx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum_q <= '0;
`endif
            end
            if (accept) begin
                case (state_q)
                    S_HDR0: nlen_q[7:0]  <= i_byte_data;
                    S_HDR1: nlen_q[15:8] <= i_byte_data;
                    S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ i_byte_data;
`endif
                        bidx_q <= bidx_q + 2'd1;
                        case (bidx_q)
                            2'd0: asm_q[7:0]   <= i_byte_data;
                            2'd1: asm_q[15:8]  <= i_byte_data;
                            2'd2: asm_q[23:16] <= i_byte_data;
                            default: begin
                                we_q    <= 1'b1;
                                waddr_q <= cnt_q[ADDR_W-1:0];
                                wdata_q <= {i_byte_data, asm_q};
                                cnt_q   <= cnt_inc;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_we    = we_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W    = 11;
    localparam int MAX_WORDS = 2048;

    logic              i_clk;
    logic              i_reset;
    logic              i_start;
    logic              i_byte_valid;
    logic [7:0]        i_byte_data;
    logic              o_byte_ready;
    logic              o_we;
    logic [ADDR_W-1:0] o_waddr;
    logic [31:0]       o_wdata;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic              o_cpu_stall;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_byte_valid(i_byte_valid),
        .i_byte_data (i_byte_data),
        .o_byte_ready(o_byte_ready),
        .o_we        (o_we),
        .o_waddr     (o_waddr),
        .o_wdata     (o_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_cpu_stall (o_cpu_stall)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Every write seen on the memory port, one entry per strobed cycle.
    logic [ADDR_W-1:0] cap_addr[$];
    logic [31:0]       cap_data[$];

    always @(negedge i_clk) begin
        if (o_we === 1'b1) begin
            cap_addr.push_back(o_waddr);
            cap_data.push_back(o_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic clear_cap();
        cap_addr.delete();
        cap_data.delete();
    endtask

    task automatic do_start();
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
    endtask

    // Present a byte sequence; gap_pct is the chance of an idle cycle (with
    // junk data) before each byte. Returns 1 ns after the last byte's edge.
    task automatic send_bytes(input logic [7:0] bq[$], input int gap_pct);
        int w;
        for (int i = 0; i < bq.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                i_byte_valid = 1'b0;
                i_byte_data  = 8'($urandom);
                step(1);
            end
            i_byte_valid = 1'b1;
            i_byte_data  = bq[i];
            w = 0;
            while (o_byte_ready !== 1'b1 && w < 50) begin
                step(1);
                w++;
            end
            if (w >= 50) begin
                chk("ready_timeout", 64'd0, 64'd1);
                i_byte_valid = 1'b0;
                return;
            end
            step(1);
        end
        i_byte_valid = 1'b0;
    endtask

    // Reference for a complete valid load: random payload, expected words
    // formed little-endian from the payload, checksum (if built) = XOR.
    task automatic good_load(input string tag, input int n, input int gap_pct);
        logic [7:0]  s[$];
        logic [7:0]  d[$];
        logic [7:0]  x;
        logic [15:0] n16;
        int          m;
        x   = 8'h00;
        n16 = 16'(n);
        for (int i = 0; i < 4 * n; i++) begin
            d.push_back(8'($urandom));
            x = x ^ d[i];
        end
        s.push_back(n16[7:0]);
        s.push_back(n16[15:8]);
        foreach (d[i]) s.push_back(d[i]);
`ifdef LOADER_CHECKSUM_EN
        s.push_back(x);
`endif
        clear_cap();
        do_start();
        chk($sformatf("%s_busy_start", tag), 64'(o_busy), 64'd1);
        chk($sformatf("%s_done_clr", tag), 64'(o_done), 64'd0);
        send_bytes(s, gap_pct);
        step(2);
        chk($sformatf("%s_nwrites", tag), 64'(cap_addr.size()), 64'(n));
        m = (cap_addr.size() < n) ? cap_addr.size() : n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(cap_addr[i]), 64'(i));
            chk($sformatf("%s_data%0d", tag, i), 64'(cap_data[i]),
                64'({d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]}));
        end
        chk($sformatf("%s_done", tag), 64'(o_done), 64'd1);
        chk($sformatf("%s_err", tag), 64'(o_err), 64'd0);
        chk($sformatf("%s_busy", tag), 64'(o_busy), 64'd0);
        chk($sformatf("%s_stall", tag), 64'(o_cpu_stall), 64'd0);
    endtask

    task automatic bad_header(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        logic [7:0] s[$];
        s.push_back(lo);
        s.push_back(hi);
        clear_cap();
        do_start();
        chk($sformatf("%s_busy_start", tag), 64'(o_busy), 64'd1);
        send_bytes(s, 0);
        step(2);
        chk($sformatf("%s_err", tag), 64'(o_err), 64'd1);
        chk($sformatf("%s_done", tag), 64'(o_done), 64'd0);
        chk($sformatf("%s_busy", tag), 64'(o_busy), 64'd0);
        chk($sformatf("%s_stall", tag), 64'(o_cpu_stall), 64'd1);
        chk($sformatf("%s_ready", tag), 64'(o_byte_ready), 64'd0);
        chk($sformatf("%s_nwrites", tag), 64'(cap_addr.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk($sformatf("%s_we", tag), 64'(o_we), 64'd0);
        chk($sformatf("%s_waddr", tag), 64'(o_waddr), 64'd0);
        chk($sformatf("%s_wdata", tag), 64'(o_wdata), 64'd0);
        chk($sformatf("%s_busy", tag), 64'(o_busy), 64'd0);
        chk($sformatf("%s_done", tag), 64'(o_done), 64'd0);
        chk($sformatf("%s_err", tag), 64'(o_err), 64'd0);
        chk($sformatf("%s_ready", tag), 64'(o_byte_ready), 64'd0);
        chk($sformatf("%s_stall", tag), 64'(o_cpu_stall), 64'd1);
    endtask

    initial begin
        logic [7:0] s[$];
        logic [7:0] d[$];

        i_reset      = 1'b1;
        i_start      = 1'b0;
        i_byte_valid = 1'b0;
        i_byte_data  = 8'h00;
        step(2);
        chk_reset_outputs("rst_held");
        i_reset = 1'b0;
        step(1);
        chk_reset_outputs("rst_rel");

        // Bytes offered in IDLE are neither taken nor stalled on.
        clear_cap();
        for (int i = 0; i < 5; i++) begin
            i_byte_valid = 1'b1;
            i_byte_data  = 8'($urandom);
            step(1);
        end
        i_byte_valid = 1'b0;
        step(1);
        chk("idle_ready", 64'(o_byte_ready), 64'd0);
        chk("idle_busy", 64'(o_busy), 64'd0);
        chk("idle_nwrites", 64'(cap_addr.size()), 64'd0);

        // Directed single-word load with exact write timing.
        clear_cap();
        s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
        do_start();
        send_bytes(s, 0);
        chk("basic_we_lat", 64'(o_we), 64'd1);
        chk("basic_waddr", 64'(o_waddr), 64'd0);
        chk("basic_wdata", 64'(o_wdata), 64'h00A00513);
        step(1);
        chk("basic_we_pulse", 64'(o_we), 64'd0);
        chk("basic_wdata_hold", 64'(o_wdata), 64'h00A00513);
        chk("basic_waddr_hold", 64'(o_waddr), 64'd0);
`ifdef LOADER_CHECKSUM_EN
        s = '{8'hB6};
        send_bytes(s, 0);
`endif
        step(1);
        chk("basic_done", 64'(o_done), 64'd1);
        chk("basic_stall", 64'(o_cpu_stall), 64'd0);
        chk("basic_busy", 64'(o_busy), 64'd0);
        chk("basic_nwrites", 64'(cap_addr.size()), 64'd1);

        // Length boundaries.
        bad_header("n0", 8'h00, 8'h00);
        bad_header("n2049", 8'h01, 8'h08);
        good_load("n2048", 2048, 0);
        chk("n2048_last_addr", 64'(cap_addr[cap_addr.size()-1]), 64'd2047);

        // Randomly throttled short loads.
        for (int k = 0; k < 4; k++) good_load($sformatf("n2_r%0d", k), 2, 40);
        good_load("n5_gap", 5, 60);

        // Reset one cycle after word 3 completes: words 0..2 land, word 3 never does.
        d.delete();
        s = '{8'h08, 8'h00};
        for (int i = 0; i < 16; i++) begin
            d.push_back(8'($urandom));
            s.push_back(d[i]);
        end
        clear_cap();
        do_start();
        send_bytes(s, 0);
        i_reset = 1'b1;
        #1;
        chk("abort_we_now", 64'(o_we), 64'd0);
        step(1);
        chk_reset_outputs("abort");
        chk("abort_nwrites", 64'(cap_addr.size()), 64'd3);
        for (int i = 0; i < 3 && i < cap_addr.size(); i++) begin
            chk($sformatf("abort_addr%0d", i), 64'(cap_addr[i]), 64'(i));
            chk($sformatf("abort_data%0d", i), 64'(cap_data[i]),
                64'({d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]}));
        end
        i_reset = 1'b0;
        step(1);
        good_load("after_abort", 1, 0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch on the same payload.
        s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        clear_cap();
        do_start();
        send_bytes(s, 0);
        step(2);
        chk("csum_ok_done", 64'(o_done), 64'd1);
        chk("csum_ok_data", 64'(cap_data.size() > 0 ? cap_data[0] : 32'hx), 64'h44332211);
        s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        clear_cap();
        do_start();
        send_bytes(s, 0);
        step(2);
        chk("csum_bad_err", 64'(o_err), 64'd1);
        chk("csum_bad_stall", 64'(o_cpu_stall), 64'd1);
        chk("csum_bad_nwrites", 64'(cap_addr.size()), 64'd1);
        chk("csum_bad_data", 64'(o_wdata), 64'h44332211);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 11, sets word-address width of the instruction memory write port.
REQ-002 Parameter MAX_WORDS, default 2048, is the largest legal program length in 32-bit words.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_start  input  1  single-cycle request to begin a load.
REQ-006 i_byte_valid  input  1  byte stream valid.
REQ-007 i_byte_data  input  8  byte stream data.
REQ-008 o_byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 o_we  output  1  instruction-memory word write strobe.
REQ-010 o_waddr  output  ADDR_W  word address of the write.
REQ-011 o_wdata  output  32  word to write.
REQ-012 o_busy  output  1  a load is in progress.
REQ-013 o_done  output  1  the last load completed successfully.
REQ-014 o_err  output  1  the last load was aborted on an error.
REQ-015 o_cpu_stall  output  1  holds the core's PC and fetch frozen.

Function
REQ-016 The FSM SHALL have the states IDLE, HDR0, HDR1, DATA, CSUM, DONE and ERR.
REQ-017 A byte SHALL transfer only in a cycle with i_byte_valid=1 and o_byte_ready=1; o_byte_ready SHALL be 1 only in HDR0, HDR1, DATA and CSUM.
REQ-018 i_start in IDLE, DONE or ERR SHALL move to HDR0, clear o_done, o_err and the word counter, and set o_busy; i_start in any other state SHALL be ignored.
REQ-019 HDR0 SHALL capture the byte as N[7:0]; HDR1 SHALL capture the byte as N[15:8] (word count N, little-endian).
REQ-020 On the HDR1 byte, N=0 or N>MAX_WORDS SHALL go to ERR; otherwise the FSM SHALL go to DATA.
REQ-021 DATA SHALL assemble bytes little-endian (first byte into bits 7:0).
REQ-022 On the 4th byte of a word, o_we SHALL pulse high for exactly the next cycle, with o_wdata set to the word and o_waddr set to the word index (0 first).
REQ-023 Back-to-back bytes SHALL be accepted with no bubbles; the write latency SHALL be 1 cycle after the 4th byte.
REQ-024 o_waddr and o_wdata SHALL hold their values between strobes.
REQ-025 After word N-1 is accepted, the FSM SHALL go to CSUM when checksum is enabled, otherwise to DONE.
REQ-026 DONE SHALL set o_done=1, o_busy=0 and o_cpu_stall=0.
REQ-027 ERR SHALL set o_err=1, o_busy=0 and keep o_cpu_stall=1.
REQ-028 o_cpu_stall SHALL be 1 in every state except DONE.
REQ-029 The word counter SHALL be ADDR_W+1 bits wide, so that N=MAX_WORDS terminates without wrap-around.
REQ-030 Bytes presented while o_byte_ready=0 SHALL be ignored and not stalled.

Reset
REQ-031 i_reset SHALL asynchronously force IDLE and clear o_we, o_waddr, o_wdata, o_busy, o_done, o_err, the counters and the checksum.
REQ-032 After reset, o_byte_ready SHALL be 0 and o_cpu_stall SHALL be 1.
REQ-033 Reset during a load SHALL abort it with no further o_we pulse, including a write pending from a 4th byte accepted in the prior cycle.

Configuration
REQ-034 With macro LOADER_CHECKSUM_EN defined, the loader SHALL keep a running XOR of all DATA bytes and take one trailing byte in CSUM.
REQ-035 With LOADER_CHECKSUM_EN defined, a CSUM byte equal to the XOR SHALL go to DONE and a mismatch SHALL go to ERR; words already written SHALL stay written.
REQ-036 Without LOADER_CHECKSUM_EN, the CSUM state and XOR logic SHALL be absent, and DATA SHALL go directly to DONE.

Verification
REQ-037 Reset, then start, then bytes 01 00 13 05 A0 00 with no gaps -> one o_we pulse, waddr=0, wdata=0x00A00513, then DONE with stall=0.
REQ-038 Header 00 00 -> ERR with o_err=1, stall=1 and no o_we pulse.
REQ-039 Header 01 08 (N=2049) -> ERR; header 00 08 (N=2048) with 8192 data bytes -> last write at waddr=2047, then DONE.
REQ-040 N=2, valid toggled randomly -> exactly 2 writes at waddr 0 and 1 with correct words, and no bytes dropped or duplicated.
REQ-041 i_reset asserted the cycle after the 4th byte of word 3 -> no o_we pulse, all outputs at reset values; a fresh start then loads from waddr 0.
REQ-042 LOADER_CHECKSUM_EN defined, N=1, word bytes 11 22 33 44, checksum 44 -> DONE; the same load with checksum 45 -> ERR with the word still written.
